// File: rtl/miriscv_run_pkg.sv
// Shared types and helpers for the miriscv run controller.
// State encoding, ADDI opcode fields and the argument encoder.
package miriscv_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } run_state_e;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI   = 3'b000;

    // ADDI rd, x0, imm
    function automatic logic [31:0] encode_addi(
        input logic [11:0] imm,
        input logic [4:0]  rd
    );
        return {imm, 5'd0, FUNCT3_ADDI, rd, OPCODE_OP_IMM};
    endfunction

endpackage

// File: rtl/miriscv_run_ctrl.sv
// Run controller: patches ADDI args into RAM, pulses core reset, runs with a budget.
// Ports: clk/rst, start, arg handshake, RAM write port, core reset, halt/result, status.
module miriscv_run_ctrl
    import miriscv_run_pkg::*;
#(
    parameter int RAM_SIZE      = 512,
    parameter int ARG_COUNT     = 1,
    parameter int ARG_BASE_ADDR = 0,
    parameter int RST_CYCLES    = 2,
    parameter int RUN_CYCLES    = 300,
    localparam int AW           = $clog2(RAM_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          arg_valid_i,
    input  logic [11:0]   arg_imm_i,
    input  logic [4:0]    arg_rd_i,
    output logic          arg_ready_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic          core_rst_n_o,
    input  logic          halt_i,
    input  logic [31:0]   result_i,
    output logic [31:0]   result_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o
);

    // Argument counter keeps at least one bit so ARG_COUNT==0 still elaborates.
    localparam int ACW = (ARG_COUNT > 0) ? $clog2(ARG_COUNT + 1) : 1;
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int UCW = $clog2(RUN_CYCLES + 1);

    localparam logic [ACW-1:0] ARG_LAST =
        ACW'((ARG_COUNT > 0) ? ARG_COUNT - 1 : 0);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [UCW-1:0] RUN_LAST = UCW'(RUN_CYCLES - 1);
    localparam logic [AW-1:0]  BASE     = AW'(ARG_BASE_ADDR);

    // With no arguments there is nothing to load.
    localparam run_state_e START_ST =
        (ARG_COUNT == 0) ? ST_RESET : ST_LOAD;

    run_state_e     state;
    logic [ACW-1:0] arg_cnt;
    logic [RCW-1:0] rst_cnt;
    logic [UCW-1:0] run_cnt;
    logic           hs;

    assign hs = (state == ST_LOAD) && arg_valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            arg_cnt     <= '0;
            rst_cnt     <= '0;
            run_cnt     <= '0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            result_o    <= '0;
            timeout_o   <= 1'b0;
        end else begin
            ram_we_o <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state     <= START_ST;
                        arg_cnt   <= '0;
                        rst_cnt   <= '0;
                        timeout_o <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        ram_we_o    <= 1'b1;
                        ram_addr_o  <= BASE + AW'(arg_cnt);
                        ram_wdata_o <= encode_addi(arg_imm_i, arg_rd_i);
                        if (arg_cnt == ARG_LAST) begin
                            state   <= ST_RESET;
                            rst_cnt <= '0;
                        end else begin
                            arg_cnt <= arg_cnt + 1'b1;
                        end
                    end
                end
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= ST_RUN;
                        run_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Halt takes priority over budget expiry.
                    if (halt_i || (run_cnt == RUN_LAST)) begin
                        state     <= ST_DONE;
                        timeout_o <= !halt_i;
                        result_o  <= result_i;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign arg_ready_o  = (state == ST_LOAD);
    assign core_rst_n_o = (state == ST_RUN);
    assign done_o       = (state == ST_DONE);
    assign busy_o       = (state == ST_LOAD) || (state == ST_RESET) ||
                          (state == ST_RUN);

endmodule

// File: tb/tb_miriscv_run_ctrl.sv
// Scoreboard bench for miriscv_run_ctrl: 3-arg instance plus a 0-arg instance.
// Stimulus pushes expected writes/results; a negedge monitor pops and compares.
module tb_miriscv_run_ctrl;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        to;
        logic [31:0] res;
        int          len;
    } dn_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        arg_valid;
    logic [11:0] arg_imm;
    logic [4:0]  arg_rd;
    logic        arg_ready;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        core_rst_n;
    logic        halt;
    logic [31:0] result_in;
    logic [31:0] result_out;
    logic        busy;
    logic        done;
    logic        timeout;

    logic        start0;
    logic        arg_ready0;
    logic        ram_we0;
    logic [8:0]  ram_addr0;
    logic [31:0] ram_wdata0;
    logic        core_rst_n0;
    logic [31:0] result_in0;
    logic [31:0] result_out0;
    logic        busy0;
    logic        done0;
    logic        timeout0;

    int errors = 0;
    int checks = 0;
    int run_len = 0;
    int wr0_cnt = 0;
    logic done_q = 1'b0;

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    // Hand-encoded ADDI vectors: (68,x2) (5,x1) (0xFFF,x31) (0,x0)
    logic [11:0] v_imm[4] = '{12'd68, 12'd5, 12'hFFF, 12'd0};
    logic [4:0]  v_rd[4]  = '{5'd2, 5'd1, 5'd31, 5'd0};
    logic [31:0] v_dat[4] = '{32'h04400113, 32'h00500093,
                              32'hFFF00F93, 32'h00000013};

    miriscv_run_ctrl #(
        .RAM_SIZE     (512),
        .ARG_COUNT    (3),
        .ARG_BASE_ADDR(16),
        .RST_CYCLES   (2),
        .RUN_CYCLES   (300)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .arg_valid_i (arg_valid),
        .arg_imm_i   (arg_imm),
        .arg_rd_i    (arg_rd),
        .arg_ready_o (arg_ready),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .core_rst_n_o(core_rst_n),
        .halt_i      (halt),
        .result_i    (result_in),
        .result_o    (result_out),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout)
    );

    miriscv_run_ctrl #(
        .RAM_SIZE     (512),
        .ARG_COUNT    (0),
        .ARG_BASE_ADDR(0),
        .RST_CYCLES   (2),
        .RUN_CYCLES   (8)
    ) dut0 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start0),
        .arg_valid_i (arg_valid),
        .arg_imm_i   (arg_imm),
        .arg_rd_i    (arg_rd),
        .arg_ready_o (arg_ready0),
        .ram_we_o    (ram_we0),
        .ram_addr_o  (ram_addr0),
        .ram_wdata_o (ram_wdata0),
        .core_rst_n_o(core_rst_n0),
        .halt_i      (1'b0),
        .result_i    (result_in0),
        .result_o    (result_out0),
        .busy_o      (busy0),
        .done_o      (done0),
        .timeout_o   (timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or done.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            done_q  = 1'b0;
        end else begin
            if (core_rst_n) run_len++;
            if (ram_we) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                chk("wr_core_in_reset", 32'(core_rst_n), 32'd0);
                if (exp_wr.size() > 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                    chk("wr_data", ram_wdata, w.data);
                end
            end
            if (done && !done_q) begin
                chk("done_expected", 32'(exp_dn.size() > 0), 32'd1);
                if (exp_dn.size() > 0) begin
                    dn_t d;
                    d = exp_dn.pop_front();
                    chk("done_timeout", 32'(timeout), 32'(d.to));
                    chk("done_result", result_out, d.res);
                    chk("run_len", 32'(run_len), 32'(d.len));
                end
                run_len = 0;
            end
            done_q = done;
            if (ram_we0) wr0_cnt++;
        end
    end

    // One full run: start, load 3 args with gaps, then halt/timeout/abort.
    task automatic do_run(input int base_v, input int halt_at,
                          input int abort_at, input logic [31:0] res_fin,
                          input int g0, input int g1, input int g2);
        int gaps[3];
        int k;
        dn_t d;
        gaps[0] = g0;
        gaps[1] = g1;
        gaps[2] = g2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(arg_ready), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_to_clr", 32'(timeout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            int v;
            wr_t w;
            v = (base_v + i) % 4;
            repeat (gaps[i]) tick();
            arg_valid = 1'b1;
            arg_imm   = v_imm[v];
            arg_rd    = v_rd[v];
            w.addr = 9'(16 + i);
            w.data = v_dat[v];
            exp_wr.push_back(w);
            tick();
            arg_valid = 1'b0;
        end
        chk("ready_drop", 32'(arg_ready), 32'd0);
        k = 0;
        while (!core_rst_n && k < 20) begin
            tick();
            k++;
        end
        chk("reset_len", 32'(k), 32'd2);
        if (abort_at < 0) begin
            d.to  = (halt_at < 0);
            d.res = res_fin;
            d.len = (halt_at < 0) ? 300 : halt_at + 1;
            exp_dn.push_back(d);
        end
        result_in = 32'h11111111;
        for (int c = 0; c < 300; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                tick();
                chk("abort_core_rst", 32'(core_rst_n), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_we", 32'(ram_we), 32'd0);
                rst_n = 1'b1;
                tick();
                return;
            end
            if (c == 40) start = 1'b1;
            if (c == halt_at) halt = 1'b1;
            if (c == halt_at || c == 299) result_in = res_fin;
            tick();
            start = 1'b0;
            if (c == halt_at) begin
                halt = 1'b0;
                break;
            end
        end
        result_in = 32'hBAD0BAD0;
        tick();
        tick();
        chk("done_hold", 32'(done), 32'd1);
        chk("result_hold", result_out, res_fin);
        chk("done_core_frozen", 32'(core_rst_n), 32'd0);
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        start      = 1'b0;
        start0     = 1'b0;
        arg_valid  = 1'b0;
        arg_imm    = '0;
        arg_rd     = '0;
        halt       = 1'b0;
        result_in  = '0;
        result_in0 = 32'h0000005A;
        repeat (3) tick();
        chk("rst_core", 32'(core_rst_n), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_ready", 32'(arg_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // valid while IDLE has no handshake partner
        arg_valid = 1'b1;
        tick();
        tick();
        arg_valid = 1'b0;
        chk("idle_valid_ignored", 32'(busy), 32'd0);

        do_run(0, 150, -1, 32'h00000000, 0, 1, 2);
        do_run(1, -1, -1, 32'hDEADBEEF, 0, 0, 0);
        do_run(2, 299, -1, 32'hCAFE0001, 3, 2, 1);
        do_run(3, -1, 50, 32'h0, 1, 0, 3);
        do_run(0, 10, -1, 32'h12345678, 0, 2, 0);

        // ARG_COUNT==0 instance: start goes straight to RESET
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("z_busy", 32'(busy0), 32'd1);
        chk("z_ready", 32'(arg_ready0), 32'd0);
        chk("z_core_rst", 32'(core_rst_n0), 32'd0);
        tick();
        tick();
        chk("z_core_run", 32'(core_rst_n0), 32'd1);
        k = 0;
        while (!done0 && k < 20) begin
            tick();
            k++;
        end
        chk("z_done", 32'(done0), 32'd1);
        chk("z_timeout", 32'(timeout0), 32'd1);
        chk("z_result", result_out0, 32'h0000005A);

        repeat (3) tick();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_dn.size()), 32'd0);
        chk("z_no_writes", 32'(wr0_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
